// File: rtl/fp_ex_stage_if.sv
// Bundle between ID/EX, the FP execute stage and EX/MEM: issue side,
// stall back-pressure and the registered result bundle.
interface fp_ex_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_rs1_data;
    logic [31:0] fp_rs1_data;
    logic [31:0] fp_rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        werf;
    logic        mwr;
    logic        b_mux;
    logic [1:0]  ir_mux;
    logic        wb_sel;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [4:0]  rd_out;
    logic        werf_out;
    logic        mwr_out;
    logic        wb_sel_out;

    modport master (
        output flush, in_valid, int_rs1_data, fp_rs1_data, fp_rs2_data, imm,
               rd, werf, mwr, b_mux, ir_mux, wb_sel,
        input  in_ready, out_valid, result, mem_addr, store_data, rd_out,
               werf_out, mwr_out, wb_sel_out
    );

    modport slave (
        input  flush, in_valid, int_rs1_data, fp_rs1_data, fp_rs2_data, imm,
               rd, werf, mwr, b_mux, ir_mux, wb_sel,
        output in_ready, out_valid, result, mem_addr, store_data, rd_out,
               werf_out, mwr_out, wb_sel_out
    );
endinterface

// File: rtl/fp_ex_stage.sv
// FP load/store execute stage: single-cycle MOVE/ADDR and a 4-cycle
// round-toward-zero single-precision FADD/FSUB (ALIGN -> ADD -> NORM).
module fp_ex_stage (
    input logic          clk,
    input logic          rst,
    fp_ex_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_e;

    localparam logic [1:0]  OP_MOVE = 2'b00;
    localparam logic [1:0]  OP_ADDR = 2'b01;
    localparam logic [1:0]  OP_FSUB = 2'b11;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    state_e      state_q, state_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic        pend_werf_q, pend_werf_d, pend_mwr_q, pend_mwr_d, pend_wb_q, pend_wb_d;
    logic        sign_q, sign_d, sub_q, sub_d, special_q, special_d;
    logic [31:0] special_val_q, special_val_d;
    logic [7:0]  exp_q, exp_d;
    logic [26:0] ma_q, ma_d, mb_q, mb_d;
    logic [27:0] sum_q, sum_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d, mem_addr_q, mem_addr_d, store_data_q, store_data_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        werf_out_q, werf_out_d, mwr_out_q, mwr_out_d, wb_sel_out_q, wb_sel_out_d;

    // Alignment datapath, driven from the operands captured at accept.
    logic [30:0] a_mag, b_mag, big_mag, small_mag;
    logic        swap, big_sign, small_sign, a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  diff;
    logic [4:0]  sh;
    logic [53:0] wide;

    // Denormals have a zero exponent and are folded to a zero magnitude here.
    assign a_mag      = (opa_q[30:23] == 8'd0) ? 31'd0 : opa_q[30:0];
    assign b_mag      = (opb_q[30:23] == 8'd0) ? 31'd0 : opb_q[30:0];
    assign swap       = b_mag > a_mag;
    assign big_mag    = swap ? b_mag : a_mag;
    assign small_mag  = swap ? a_mag : b_mag;
    assign big_sign   = swap ? opb_q[31] : opa_q[31];
    assign small_sign = swap ? opa_q[31] : opb_q[31];
    assign diff       = big_mag[30:23] - small_mag[30:23];
    assign sh         = (diff > 8'd27) ? 5'd27 : diff[4:0];
    assign wide       = {|small_mag[30:23], small_mag[22:0], 30'd0} >> sh;
    assign a_nan      = (&opa_q[30:23]) && (|opa_q[22:0]);
    assign b_nan      = (&opb_q[30:23]) && (|opb_q[22:0]);
    assign a_inf      = (&opa_q[30:23]) && !(|opa_q[22:0]);
    assign b_inf      = (&opb_q[30:23]) && !(|opb_q[22:0]);

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) n = 5'(26 - i);
        return n;
    endfunction

    logic [4:0]  lz;
    logic [26:0] norm_m;
    logic [9:0]  exp_n;
    logic [31:0] fp_res;

    // NOTE: every signal written in always_comb gets a value on entry, so no path can infer a latch.
    always_comb begin
        lz     = lzc27(sum_q[26:0]);
        norm_m = sum_q[26:0] << lz;
        exp_n  = {2'b00, exp_q} - {5'd0, lz};
        if (sum_q[27]) begin
            norm_m = sum_q[27:1];
            exp_n  = {2'b00, exp_q} + 10'd1;
        end
        fp_res = {sign_q, exp_n[7:0], norm_m[25:3]};
        if (special_q)
            fp_res = special_val_q;
        else if (sum_q == 28'd0)
            fp_res = {sign_q & ~sub_q, 31'd0};
        else if (!exp_n[9] && exp_n >= 10'd255)
            fp_res = {sign_q, 31'h7F7F_FFFF};
        else if (exp_n[9] || exp_n == 10'd0)
            fp_res = 32'd0;
    end

    always_comb begin
        state_d       = state_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        pend_rd_d     = pend_rd_q;
        pend_werf_d   = pend_werf_q;
        pend_mwr_d    = pend_mwr_q;
        pend_wb_d     = pend_wb_q;
        sign_d        = sign_q;
        sub_d         = sub_q;
        special_d     = special_q;
        special_val_d = special_val_q;
        exp_d         = exp_q;
        ma_d          = ma_q;
        mb_d          = mb_q;
        sum_d         = sum_q;
        out_valid_d   = 1'b0;
        result_d      = result_q;
        mem_addr_d    = mem_addr_q;
        store_data_d  = store_data_q;
        rd_out_d      = rd_out_q;
        werf_out_d    = werf_out_q;
        mwr_out_d     = mwr_out_q;
        wb_sel_out_d  = wb_sel_out_q;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (bus.in_valid) begin
                    if (bus.ir_mux[1]) begin
                        state_d     = ALIGN;
                        opa_d       = bus.fp_rs1_data;
                        opb_d       = bus.b_mux ? bus.imm : bus.fp_rs2_data;
                        opb_d[31]   = opb_d[31] ^ (bus.ir_mux == OP_FSUB);
                        pend_rd_d   = bus.rd;
                        pend_werf_d = bus.werf;
                        pend_mwr_d  = bus.mwr;
                        pend_wb_d   = bus.wb_sel;
                    end else begin
                        out_valid_d  = 1'b1;
                        result_d     = (bus.ir_mux == OP_MOVE) ? bus.int_rs1_data : 32'd0;
                        mem_addr_d   = (bus.ir_mux == OP_ADDR) ? bus.int_rs1_data + bus.imm : 32'd0;
                        store_data_d = (bus.ir_mux == OP_ADDR) ? bus.fp_rs2_data : 32'd0;
                        rd_out_d     = bus.rd;
                        werf_out_d   = bus.werf;
                        mwr_out_d    = bus.mwr;
                        wb_sel_out_d = bus.wb_sel;
                    end
                end
                ALIGN: begin
                    state_d       = ADD;
                    sign_d        = big_sign;
                    sub_d         = big_sign ^ small_sign;
                    exp_d         = big_mag[30:23];
                    ma_d          = {|big_mag[30:23], big_mag[22:0], 3'b000};
                    mb_d          = {wide[53:28], wide[27] | (|wide[26:0])};
                    special_d     = a_nan || b_nan || a_inf || b_inf;
                    special_val_d = a_inf ? {opa_q[31], 31'h7F80_0000} : {opb_q[31], 31'h7F80_0000};
                    if (a_nan || b_nan || (a_inf && b_inf && (opa_q[31] != opb_q[31])))
                        special_val_d = QNAN;
                end
                ADD: begin
                    state_d = NORM;
                    sum_d   = sub_q ? {1'b0, ma_q} - {1'b0, mb_q} : {1'b0, ma_q} + {1'b0, mb_q};
                end
                NORM: begin
                    state_d      = IDLE;
                    out_valid_d  = 1'b1;
                    result_d     = fp_res;
                    mem_addr_d   = 32'd0;
                    store_data_d = 32'd0;
                    rd_out_d     = pend_rd_q;
                    werf_out_d   = pend_werf_q;
                    mwr_out_d    = pend_mwr_q;
                    wb_sel_out_d = pend_wb_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the whole datapath is reset, since the bundle outputs must read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            opa_q         <= '0;
            opb_q         <= '0;
            pend_rd_q     <= '0;
            pend_werf_q   <= 1'b0;
            pend_mwr_q    <= 1'b0;
            pend_wb_q     <= 1'b0;
            sign_q        <= 1'b0;
            sub_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            exp_q         <= '0;
            ma_q          <= '0;
            mb_q          <= '0;
            sum_q         <= '0;
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            mem_addr_q    <= '0;
            store_data_q  <= '0;
            rd_out_q      <= '0;
            werf_out_q    <= 1'b0;
            mwr_out_q     <= 1'b0;
            wb_sel_out_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            pend_rd_q     <= pend_rd_d;
            pend_werf_q   <= pend_werf_d;
            pend_mwr_q    <= pend_mwr_d;
            pend_wb_q     <= pend_wb_d;
            sign_q        <= sign_d;
            sub_q         <= sub_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            exp_q         <= exp_d;
            ma_q          <= ma_d;
            mb_q          <= mb_d;
            sum_q         <= sum_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            mem_addr_q    <= mem_addr_d;
            store_data_q  <= store_data_d;
            rd_out_q      <= rd_out_d;
            werf_out_q    <= werf_out_d;
            mwr_out_q     <= mwr_out_d;
            wb_sel_out_q  <= wb_sel_out_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.store_data = store_data_q;
    assign bus.rd_out     = rd_out_q;
    assign bus.werf_out   = out_valid_q & werf_out_q;
    assign bus.mwr_out    = out_valid_q & mwr_out_q;
    assign bus.wb_sel_out = wb_sel_out_q;
endmodule

// File: doc/fp_ex_stage.md
# fp_ex_stage

Execute stage of the FP load/store pipeline, directly downstream of the ID/EX register; it consumes the registered operands and control, then produces one registered result bundle per instruction for the EX/MEM register.
- Single-cycle ops: integer-to-FP move and load/store address generation.
- Multi-cycle op: single-precision FADD/FSUB, round-toward-zero, with a valid/ready stall back to ID/EX.

## Interface
Parameters:
- none (datapath fixed at 32 bits, rd at 5 bits)

Ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of any in-flight op; the current input is not accepted
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage can accept; ID/EX must hold its contents while low
- int_rs1_data  in  32  integer rs1 value
- fp_rs1_data  in  32  FP operand A
- fp_rs2_data  in  32  FP operand B / store data
- imm  in  32  sign-extended immediate
- rd  in  5  destination register
- werf  in  1  register-file write enable
- mwr  in  1  memory write enable
- b_mux  in  1  FP B select: 0 = fp_rs2_data, 1 = imm
- ir_mux  in  2  op select: 00 MOVE, 01 ADDR, 10 FADD, 11 FSUB
- wb_sel  in  1  writeback select, passed through unchanged
- out_valid  out  1  one-cycle pulse; the result bundle is valid
- result  out  32  MOVE/FADD/FSUB result; 0 for ADDR
- mem_addr  out  32  int_rs1_data + imm (ADDR only, else 0)
- store_data  out  32  fp_rs2_data captured at accept (ADDR only, else 0)
- rd_out  out  5  rd captured at accept
- werf_out  out  1  werf captured at accept, gated by out_valid
- mwr_out  out  1  mwr captured at accept, gated by out_valid
- wb_sel_out  out  1  wb_sel captured at accept

## Operation
- Accept when in_valid && in_ready && !flush; all inputs are captured at that edge.
- MOVE: result = int_rs1_data.
- ADDR: mem_addr = int_rs1_data + imm, mod 2^32.
- FADD: A + B. FSUB: A + (B with sign bit inverted).
- FSM states: IDLE, ALIGN, ADD, NORM.
  - in_ready = (state == IDLE).
  - FP accept: IDLE→ALIGN. Then ALIGN→ADD→NORM→IDLE unconditionally.
  - ALIGN: unpack, swap so |A| ≥ |B|, right-shift the smaller mantissa with guard/round/sticky.
  - ADD: add or subtract the mantissas.
  - NORM: leading-zero normalize, truncate, pack.
- FP rules:
  - Result equals the IEEE-754 round-toward-zero result for normal operands.
  - Denormal inputs are treated as ±0. Denormal results flush to +0.
  - Exact cancellation gives +0.
  - Overflow gives ±0x7F7FFFFF, the max finite value under RTZ.
  - Any NaN input, or inf − inf, gives 0x7FC00000.
  - inf combined with a finite operand gives that inf.
- werf_out and mwr_out are 0 whenever out_valid is 0. There is no downstream backpressure.

## Timing
- Reset values:
  - state IDLE, so in_ready = 1.
  - out_valid, result, mem_addr, store_data, rd_out, werf_out, mwr_out, wb_sel_out all 0.
- MOVE/ADDR accepted at edge E0: the bundle is registered at E0 and out_valid is high for the cycle after E0. Back-to-back accepts every cycle are allowed.
- FADD/FSUB accepted at E0:
  - in_ready is low after E0, E1 and E2.
  - The bundle is registered at E3 and out_valid is high for the cycle after E3.
  - in_ready is high after E3, so the next accept is at E4 at the earliest.
  - Throughput is one FP op per 4 cycles.
- Flush:
  - flush high at an edge forces state IDLE and out_valid 0 after that edge; the in-flight op is dropped with no output.
  - flush has priority over completion at E3.
- rst mid-op: immediate asynchronous return to the reset values; no output is ever produced for the killed op.

## Test plan
- FADD 0x3F800000 + 0x40000000 → result 0x40400000.
  - out_valid exactly 4 edges after accept; in_ready low for 3 cycles.
  - rd_out and werf_out match the captured inputs.
- FSUB edge cases:
  - 0x3F800000 − 0x3F800000 → 0x00000000.
  - 0x3F800000 − 0x30800000 → 0x3F7FFFFF (RTZ).
  - b_mux=1 with imm=0x40000000, FADD with A=0x3F800000 → 0x40400000.
- ADDR: int_rs1=0x00001000, imm=0xFFFFFFFC, fp_rs2=0xDEADBEEF, mwr=1 → mem_addr 0x00000FFC, store_data 0xDEADBEEF, mwr_out=1.
  - Three back-to-back ADDR/MOVE ops give three consecutive out_valid pulses.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F7FFFFF.
  - Denormal 0x00000001 + 0x3F800000 → 0x3F800000.
- Flush in ALIGN: no out_valid pulse and werf_out stays 0. in_ready = 1 the next cycle, and a following MOVE completes normally.
- rst asserted during ADD: all outputs 0 and in_ready = 1 immediately. After release, a FADD completes with the correct value.
